// File: rtl/moore_overlapping_1011_if.sv
// Serial bit-stream bus for the 1011 detector: one data bit in, one flag out.
interface moore_overlapping_1011_if;
  logic data;
  logic detected;

  modport master (
    output data,
    input  detected
  );

  modport slave (
    input  data,
    output detected
  );
endinterface

// File: rtl/moore_overlapping_1011.sv
// Overlapping Moore detector for the serial pattern 1011; flag is decoded
// from the state register only, so it lags the fourth bit by one edge.
module moore_overlapping_1011 (
  input  logic                      clk,
  input  logic                      rst,
  moore_overlapping_1011_if.slave   bus
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // S4 falls back to S1/S2 so the trailing "1" (or "10") seeds the next match.
  always_comb begin
    state_d = S0;
    unique case (state_q)
      S0:      state_d = bus.data ? S1 : S0;
      S1:      state_d = bus.data ? S1 : S2;
      S2:      state_d = bus.data ? S3 : S0;
      S3:      state_d = bus.data ? S4 : S2;
      S4:      state_d = bus.data ? S1 : S2;
      default: state_d = S0;
    endcase
  end

  always_comb begin
    bus.detected = 1'b0;
    if (state_q == S4) begin
      bus.detected = 1'b1;
    end
  end

endmodule

// File: tb/tb_moore_overlapping_1011.sv
// Directed bench for the 1011 detector with a queued scoreboard and monitor.
module tb_moore_overlapping_1011;

  logic clk;
  logic rst;

  moore_overlapping_1011_if bus ();

  moore_overlapping_1011 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic  exp;
    string name;
    int    idx;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Inputs change on the falling edge; the expectation pushed with each
  // input is the flag visible just after the rising edge that samples it.
  task automatic step(input logic r, input logic d, input logic e,
                      input string nm, input int idx);
    sb_item_t it;
    @(negedge clk);
    rst      = r;
    bus.data = d;
    it.exp   = e;
    it.name  = nm;
    it.idx   = idx;
    sb.push_back(it);
  endtask

  task automatic run(input string nm, input string bits, input string exps);
    for (int i = 0; i < bits.len(); i++) begin
      step(1'b1, bits[i] == "1", exps[i] == "1", nm, i);
    end
  endtask

  task automatic do_reset(input string nm);
    step(1'b0, 1'b1, 1'b0, nm, 0);
  endtask

  initial begin
    sb_item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (bus.detected !== it.exp) begin
          errors++;
          $display("FAIL %s[%0d]: detected=%b expected=%b at %0t",
                   it.name, it.idx, bus.detected, it.exp, $time);
        end
      end
    end
  end

  initial begin
    int budget;
    rst      = 1'b0;
    bus.data = 1'b1;

    step(1'b0, 1'b1, 1'b0, "reset_hold", 0);
    step(1'b0, 1'b1, 1'b0, "reset_hold", 1);

    run("single", "10110", "00010");
    do_reset("rst_a");

    run("overlap", "1011011011011011011011011011",
                   "0001001001001001001001001001");
    do_reset("rst_b");

    run("nearmiss_10011", "10011", "00000");
    do_reset("rst_c");

    run("selfloop_11011", "11011", "00001");
    do_reset("rst_d");

    run("recover_101011", "101011", "000001");
    do_reset("rst_e");

    run("mid_pre_a", "101", "000");
    do_reset("mid_rst_a");
    run("mid_post_1", "10", "00");
    do_reset("rst_f");

    run("mid_pre_b", "101", "000");
    do_reset("mid_rst_b");
    run("mid_post_011", "0110", "0000");
    do_reset("rst_g");

    run("mid_pre_c", "101", "000");
    do_reset("mid_rst_c");
    run("mid_post_1011", "10110", "00010");

    run("s4_pre", "1011", "0001");
    do_reset("s4_rst");
    run("s4_post", "1011", "0001");

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
